viterbi_traceback: RTL

//  Survivor memory + traceback stage downstream of the four per-state ACS units (K=3, 4 states).

---
 rtl/viterbi_traceback_if.sv | 28 ++
 rtl/viterbi_traceback.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_if.sv
// Stream interface for the Viterbi traceback stage: an upstream trellis-step
// channel (survivors + path metrics) and a downstream decoded-bit channel.
interface viterbi_traceback_if #(
    parameter int PM_W = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_surv;
    logic [4*PM_W-1:0]   in_pm;
    logic                in_last;
    logic                in_term;
    logic                out_valid;
    logic                out_ready;
    logic                out_bit;
    logic                out_last;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_surv, in_pm, in_last, in_term, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    // Traceback block side
    modport slave (
        input  in_valid, in_surv, in_pm, in_last, in_term, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for a K=3 (4-state) Viterbi decoder.
// FILL stores one survivor word per trellis step, TRACE walks the survivor
// pointers backwards from the chosen end state writing decoded bits, and
// EMIT streams those bits out oldest-first over a valid/ready handshake.
module viterbi_traceback #(
    parameter int FRAME_MAX = 32,
    parameter int PM_W      = 7
) (
    input  logic               clk,
    input  logic               rst,
    viterbi_traceback_if.slave bus
);
    localparam int IW    = $clog2(FRAME_MAX);
    localparam int LEN_W = IW + 1;

    localparam logic [IW-1:0]    IDX_ZERO = IW'(0);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(FRAME_MAX - 1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_TRACE = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    // Lowest-index state with the smallest unsigned path metric.
    function automatic logic [1:0] pm_argmin(input logic [4*PM_W-1:0] pm);
        logic [PM_W-1:0] best;
        logic [1:0]      sel;
        best = pm[PM_W-1:0];
        sel  = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm[i*PM_W +: PM_W] < best) begin
                best = pm[i*PM_W +: PM_W];
                sel  = 2'(i);
            end else begin
                best = best;
            end
        end
        return sel;
    endfunction

    state_t           r_state;
    logic [IW-1:0]    r_wr_idx;
    logic [LEN_W-1:0] r_len;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_st;
    logic [IW-1:0]    r_rd_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_bit;
    logic             r_out_last;

    logic [7:0]       r_surv_mem [FRAME_MAX];
    logic             r_bit_mem  [FRAME_MAX];

    logic             w_accept;
    logic             w_final;
    logic [1:0]       w_start;
    logic [1:0]       w_pred;
    logic [LEN_W-1:0] w_next_rd;
    logic [LEN_W-1:0] w_len_m1;

    assign w_accept  = (r_state == S_FILL) && r_in_ready && bus.in_valid;
    // A frame ends on in_last or when the survivor RAM is full.
    assign w_final   = w_accept && (bus.in_last || (r_wr_idx == IDX_LAST));
    // Termination is only honoured on an explicit in_last; a forced end
    // always traces from the best metric.
    assign w_start   = (bus.in_last && bus.in_term) ? 2'd0 : pm_argmin(bus.in_pm);
    // Predecessor of the current trace state at the current step.
    assign w_pred    = r_surv_mem[r_idx][{r_st, 1'b0} +: 2];
    assign w_next_rd = {1'b0, r_rd_idx} + LEN_ONE;
    assign w_len_m1  = r_len - LEN_ONE;

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_wr_idx    <= IDX_ZERO;
            r_len       <= LEN_ZERO;
            r_idx       <= IDX_ZERO;
            r_st        <= 2'd0;
            r_rd_idx    <= IDX_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_wr_idx <= r_wr_idx + IDX_ONE;
                        if (w_final) begin
                            r_len      <= {1'b0, r_wr_idx} + LEN_ONE;
                            r_idx      <= r_wr_idx;
                            r_st       <= w_start;
                            r_in_ready <= 1'b0;
                            r_state    <= S_TRACE;
                        end
                    end
                end
                S_TRACE: begin
                    r_st <= w_pred;
                    if (r_idx == IDX_ZERO) begin
                        // Bit 0 is being written to bit_mem this cycle, so
                        // feed it straight to the output register.
                        r_state     <= S_EMIT;
                        r_rd_idx    <= IDX_ZERO;
                        r_out_valid <= 1'b1;
                        r_out_bit   <= r_st[1];
                        r_out_last  <= (r_len == LEN_ONE);
                    end else begin
                        r_idx <= r_idx - IDX_ONE;
                    end
                end
                S_EMIT: begin
                    if (r_out_valid && bus.out_ready) begin
                        if ({1'b0, r_rd_idx} == w_len_m1) begin
                            r_out_valid <= 1'b0;
                            r_out_bit   <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_wr_idx    <= IDX_ZERO;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_FILL;
                        end else begin
                            r_rd_idx   <= w_next_rd[IW-1:0];
                            r_out_bit  <= r_bit_mem[w_next_rd[IW-1:0]];
                            r_out_last <= (w_next_rd == w_len_m1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_FILL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_bit   <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Survivor RAM: one 4x2-bit predecessor word per accepted trellis step.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_surv_mem[r_wr_idx] <= bus.in_surv;
        end
    end

    // Decoded-bit RAM: the MSB of each traced state is the input bit at that step.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_TRACE)) begin
            r_bit_mem[r_idx] <= r_st[1];
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_last  = r_out_last;
endmodule
